lsu_16b: RTL and testbench

Load/store unit for the 65HE06 core: consumes the effective address and store payload computed by the ALU/AGU and executes the memory transfer on the core's 8-bit external data bus. 16-bit words are moved as two little-endian byte cycles; 8-bit accesses take one cycle. Load results are returned to the register file with a one-cycle write strobe, and the scheduler stalls on `sched_busy`.

---
 rtl/lsu_16b_pkg.sv | 15 +
 rtl/lsu_16b.sv | 96 +++++++++
 tb/tb_lsu_16b.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_16b_pkg.sv
// Shared 65HE06 core definitions for the load/store unit: FSM encoding and
// the access-size values the scheduler drives on sched_byte.
package lsu_16b_pkg;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_LO   = 2'd1,
        LSU_HI   = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_t;

    localparam logic ACC_WORD = 1'b0;
    localparam logic ACC_BYTE = 1'b1;

endpackage

// File: rtl/lsu_16b.sv
// Load/store unit: moves 8- or 16-bit operands over the 8-bit external bus as
// little-endian byte cycles and returns load results to the register file.
module lsu_16b
    import lsu_16b_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sched_req,
    input  logic        sched_we,
    input  logic        sched_byte,
    output logic        sched_busy,
    input  logic [15:0] alu_adr,
    input  logic [15:0] alu_payload,
    output logic        rf_wr,
    output logic [15:0] rf_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_adr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    input  logic        mem_rdy
);

    lsu_state_t  state_q, state_d;
    logic [15:0] adr_q;
    logic [15:0] payload_q;
    logic        we_q;
    logic        byte_q;
    logic [7:0]  lo_q;
    logic [15:0] rf_data_q;
    logic        accept;
    logic        in_xfer;

    assign accept  = sched_req && ((state_q == LSU_IDLE) || (state_q == LSU_DONE));
    assign in_xfer = (state_q == LSU_LO) || (state_q == LSU_HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LSU_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: if (accept) state_d = LSU_LO;
            LSU_LO: begin
                if (mem_rdy) state_d = (byte_q == ACC_BYTE) ? LSU_DONE : LSU_HI;
            end
            LSU_HI:   if (mem_rdy) state_d = LSU_DONE;
            LSU_DONE: state_d = accept ? LSU_LO : LSU_IDLE;
            default:  state_d = LSU_IDLE;
        endcase
    end

    // rf_data is only updated on the edge entering DONE, so it holds steady
    // while the next load is still collecting its bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adr_q     <= 16'h0000;
            payload_q <= 16'h0000;
            we_q      <= 1'b0;
            byte_q    <= 1'b0;
            lo_q      <= 8'h00;
            rf_data_q <= 16'h0000;
        end else begin
            if (accept) begin
                adr_q     <= alu_adr;
                payload_q <= alu_payload;
                we_q      <= sched_we;
                byte_q    <= sched_byte;
            end
            if ((state_q == LSU_LO) && mem_rdy && !we_q) begin
                if (byte_q == ACC_BYTE) begin
                    rf_data_q <= {8'h00, mem_din};
                end else begin
                    lo_q <= mem_din;
                end
            end
            if ((state_q == LSU_HI) && mem_rdy && !we_q) begin
                rf_data_q <= {mem_din, lo_q};
            end
        end
    end

    assign sched_busy = in_xfer;
    assign mem_req    = in_xfer;
    assign mem_we     = in_xfer && we_q;
    assign mem_adr    = (state_q == LSU_HI) ? (adr_q + 16'd1) : adr_q;
    assign mem_dout   = (state_q == LSU_HI) ? payload_q[15:8] : payload_q[7:0];
    assign rf_wr      = (state_q == LSU_DONE) && !we_q;
    assign rf_data    = rf_data_q;

endmodule

// File: tb/tb_lsu_16b.sv
// Testbench for lsu_16b: directed and random transfers against a byte-array
// memory model and an expected-memory image kept by the bench.
module tb_lsu_16b;
    import lsu_16b_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sched_req = 1'b0;
    logic        sched_we = 1'b0;
    logic        sched_byte = 1'b0;
    logic        sched_busy;
    logic [15:0] alu_adr = 16'h0000;
    logic [15:0] alu_payload = 16'h0000;
    logic        rf_wr;
    logic [15:0] rf_data;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_adr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din = 8'h00;
    logic        mem_rdy = 1'b0;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] last_rf = 16'h0000;
    logic [7:0]  bus_mem [0:65535];
    logic [7:0]  ref_mem [0:65535];

    lsu_16b dut (
        .clk         (clk),
        .rst         (rst),
        .sched_req   (sched_req),
        .sched_we    (sched_we),
        .sched_byte  (sched_byte),
        .sched_busy  (sched_busy),
        .alu_adr     (alu_adr),
        .alu_payload (alu_payload),
        .rf_wr       (rf_wr),
        .rf_data     (rf_data),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_adr     (mem_adr),
        .mem_dout    (mem_dout),
        .mem_din     (mem_din),
        .mem_rdy     (mem_rdy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_busy"}, 16'(sched_busy), 16'd0);
        checkOutput({tag, "_req"},  16'(mem_req),    16'd0);
        checkOutput({tag, "_we"},   16'(mem_we),     16'd0);
        checkOutput({tag, "_rfwr"}, 16'(rf_wr),      16'd0);
        checkOutput({tag, "_rfdata"}, rf_data, last_rf);
    endtask

    // One idle cycle with stray bus ready/data that the unit must ignore.
    task automatic idleCycle(input string tag);
        sched_req = 1'b0;
        mem_rdy   = 1'($urandom_range(0, 1));
        mem_din   = 8'($urandom);
        @(posedge clk); #1;
        checkQuiet(tag);
    endtask

    // Checks one bus cycle and plays the memory side of it.
    task automatic busCycle(input string tag, input logic [15:0] exp_adr,
                            input logic [7:0] exp_dout, input logic we, input logic rdy);
        mem_rdy = rdy;
        mem_din = rdy ? bus_mem[mem_adr] : 8'($urandom);
        checkOutput({tag, "_busy"}, 16'(sched_busy), 16'd1);
        checkOutput({tag, "_req"},  16'(mem_req),    16'd1);
        checkOutput({tag, "_we"},   16'(mem_we),     16'(we));
        checkOutput({tag, "_adr"},  mem_adr,         exp_adr);
        checkOutput({tag, "_dout"}, 16'(mem_dout),   16'(exp_dout));
        checkOutput({tag, "_rfwr"}, 16'(rf_wr),      16'd0);
        checkOutput({tag, "_rfdata"}, rf_data, last_rf);
        if (rdy && mem_req && mem_we) bus_mem[mem_adr] = mem_dout;
    endtask

    // Full transfer from request to DONE; returns sampling inside DONE so a
    // following call exercises the back-to-back accept.
    task automatic applyStimulus(input logic we, input logic byt, input logic [15:0] adr,
                                 input logic [15:0] payload, input int wlo, input int whi,
                                 input bit pulse);
        logic [15:0] adr_hi;
        logic [15:0] exp_rd;
        bit          first;
        adr_hi = adr + 16'd1;
        exp_rd = (byt == ACC_BYTE) ? {8'h00, ref_mem[adr]} : {ref_mem[adr_hi], ref_mem[adr]};
        sched_req   = 1'b1;
        sched_we    = we;
        sched_byte  = byt;
        alu_adr     = adr;
        alu_payload = payload;
        @(posedge clk); #1;
        first = 1'b1;
        for (int k = 0; k <= wlo; k++) begin
            sched_req = pulse && first;
            if (sched_req) begin
                alu_adr     = ~adr;
                alu_payload = ~payload;
                sched_we    = ~we;
                sched_byte  = ~byt;
            end
            first = 1'b0;
            busCycle("lo", adr, payload[7:0], we, 1'(k == wlo));
            @(posedge clk); #1;
        end
        if (byt == ACC_WORD) begin
            for (int k = 0; k <= whi; k++) begin
                sched_req = 1'b0;
                busCycle("hi", adr_hi, payload[15:8], we, 1'(k == whi));
                @(posedge clk); #1;
            end
        end
        sched_req = 1'b0;
        mem_rdy   = 1'b0;
        checkOutput("done_busy", 16'(sched_busy), 16'd0);
        checkOutput("done_req",  16'(mem_req),    16'd0);
        checkOutput("done_we",   16'(mem_we),     16'd0);
        checkOutput("done_rfwr", 16'(rf_wr),      16'(!we));
        checkOutput("done_rfdata", rf_data, we ? last_rf : exp_rd);
        if (!we) begin
            last_rf = exp_rd;
        end else begin
            ref_mem[adr] = payload[7:0];
            if (byt == ACC_WORD) ref_mem[adr_hi] = payload[15:8];
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            bus_mem[i] = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        bus_mem[16'h1234] = 8'hCD; ref_mem[16'h1234] = 8'hCD;
        bus_mem[16'h1235] = 8'hAB; ref_mem[16'h1235] = 8'hAB;
        bus_mem[16'h00FF] = 8'h80; ref_mem[16'h00FF] = 8'h80;
        bus_mem[16'hFFFF] = 8'h11; ref_mem[16'hFFFF] = 8'h11;
        bus_mem[16'h0000] = 8'h22; ref_mem[16'h0000] = 8'h22;

        #2;
        checkQuiet("reset");
        checkOutput("reset_adr",  mem_adr,           16'h0000);
        checkOutput("reset_dout", 16'(mem_dout),     16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
        idleCycle("idle0");

        applyStimulus(1'b0, ACC_WORD, 16'h1234, 16'h5555, 0, 0, 1'b0);
        idleCycle("idle1");
        applyStimulus(1'b1, ACC_WORD, 16'h0200, 16'hBEEF, 0, 2, 1'b0);
        idleCycle("idle2");
        applyStimulus(1'b0, ACC_WORD, 16'h0200, 16'h0000, 1, 0, 1'b0);
        idleCycle("idle3");
        applyStimulus(1'b0, ACC_BYTE, 16'h00FF, 16'h1234, 0, 0, 1'b0);
        idleCycle("idle4");
        applyStimulus(1'b0, ACC_WORD, 16'hFFFF, 16'h0000, 0, 0, 1'b0);

        applyStimulus(1'b1, ACC_BYTE, 16'h0300, 16'h00A5, 0, 0, 1'b0);
        applyStimulus(1'b0, ACC_WORD, 16'h02FF, 16'h0000, 0, 0, 1'b1);
        idleCycle("idle5");
        idleCycle("idle6");

        // Abort a word load during its high byte.
        sched_req   = 1'b1;
        sched_we    = 1'b0;
        sched_byte  = ACC_WORD;
        alu_adr     = 16'h4321;
        alu_payload = 16'h9876;
        @(posedge clk); #1;
        sched_req = 1'b0;
        mem_rdy   = 1'b1;
        mem_din   = 8'h5A;
        @(posedge clk); #1;
        mem_rdy = 1'b0;
        checkOutput("pre_rst_adr",  mem_adr,          16'h4322);
        checkOutput("pre_rst_busy", 16'(sched_busy),  16'd1);
        rst = 1'b1;
        #1;
        last_rf = 16'h0000;
        checkQuiet("mid_rst");
        checkOutput("mid_rst_adr",  mem_adr,          16'h0000);
        checkOutput("mid_rst_dout", 16'(mem_dout),    16'h0000);
        @(posedge clk); #1;
        rst = 1'b0;
        idleCycle("post_rst");
        applyStimulus(1'b0, ACC_WORD, 16'h1234, 16'h0000, 1, 1, 1'b0);
        idleCycle("idle7");

        for (int n = 0; n < 40; n++) begin
            logic [15:0] adr;
            adr = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - $urandom_range(0, 1))
                                              : 16'($urandom_range(16'h0100, 16'h011F));
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), adr,
                          16'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                          $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) idleCycle("rand_idle");
        end
        idleCycle("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
